// File: rtl/cook_timer_ctrl.sv
// Microwave cook-time controller: edits a min:sec time from button pulses and
// UART presets, counts it down in 1 s steps and reports IDLE/COOK/PAUSE/DONE.
module cook_timer_ctrl #(
   parameter int unsigned TICK_DIV  = 100_000_000,
   parameter int unsigned STEP_SEC  = 10,
   parameter int unsigned MAX_MIN   = 59,
   parameter int unsigned DONE_SECS = 3
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       up_pulse,
   input  logic       dwn_pulse,
   input  logic       start_pulse,
   input  logic       load_valid,
   input  logic [5:0] load_minutes,
   input  logic [5:0] load_seconds,
   output logic [5:0] minutes,
   output logic [5:0] seconds,
   output logic       start,
   output logic       idle,
   output logic       paused,
   output logic       done
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam int unsigned DW = $clog2(DONE_SECS + 1);

   typedef enum logic [1:0] {S_IDLE, S_COOK, S_PAUSE, S_DONE} state_t;

   state_t        state;
   logic [PW-1:0] presc;
   logic [DW-1:0] done_cnt;

   logic [6:0] up_sec_sum, up_sec_wrap, up_min_sum;
   logic [5:0] up_min, up_sec, dn_min, dn_sec, dec_min, dec_sec, ld_min, ld_sec;
   logic       tick, time_zero, dec_zero;

   function automatic logic [3:0] flags_of(input state_t s);
      return {s == S_COOK, s == S_IDLE, s == S_PAUSE, s == S_DONE};
   endfunction

   // Candidate times for up/down/decrement/load, all saturating or clamped.
   always_comb begin
      up_sec_sum  = 7'(seconds) + 7'(STEP_SEC);
      up_sec_wrap = (up_sec_sum >= 7'd60) ? (up_sec_sum - 7'd60) : up_sec_sum;
      up_min_sum  = (up_sec_sum >= 7'd60) ? (7'(minutes) + 7'd1) : 7'(minutes);
      if (up_min_sum > 7'(MAX_MIN)) begin
         up_min = 6'(MAX_MIN);
         up_sec = 6'd59;
      end else begin
         up_min = up_min_sum[5:0];
         up_sec = up_sec_wrap[5:0];
      end

      if (seconds >= 6'(STEP_SEC)) begin
         dn_min = minutes;
         dn_sec = seconds - 6'(STEP_SEC);
      end else if (minutes == 6'd0) begin
         dn_min = 6'd0;
         dn_sec = 6'd0;
      end else begin
         dn_min = minutes - 6'd1;
         dn_sec = 6'(7'(seconds) + 7'(60 - STEP_SEC));
      end

      if (seconds == 6'd0) begin
         dec_min = minutes - 6'd1;
         dec_sec = 6'd59;
      end else begin
         dec_min = minutes;
         dec_sec = seconds - 6'd1;
      end

      ld_min = (load_minutes > 6'(MAX_MIN)) ? 6'(MAX_MIN) : load_minutes;
      ld_sec = (load_seconds > 6'd59) ? 6'd59 : load_seconds;
   end

   assign tick      = (presc == PW'(TICK_DIV - 1));
   assign time_zero = (minutes == 6'd0) && (seconds == 6'd0);
   assign dec_zero  = (minutes == 6'd0) && (seconds == 6'd1);

   // State, time, prescaler and status flags; start > load > up > down.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state                      <= S_IDLE;
         minutes                    <= 6'd0;
         seconds                    <= 6'd0;
         presc                      <= '0;
         done_cnt                   <= '0;
         {start, idle, paused, done} <= 4'b0100;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_pulse) begin
                  if (!time_zero) begin
                     state                      <= S_COOK;
                     presc                      <= '0;
                     {start, idle, paused, done} <= flags_of(S_COOK);
                  end
               end else if (load_valid) begin
                  minutes <= ld_min;
                  seconds <= ld_sec;
               end else if (up_pulse) begin
                  minutes <= up_min;
                  seconds <= up_sec;
               end else if (dwn_pulse) begin
                  minutes <= dn_min;
                  seconds <= dn_sec;
               end
            end
            S_COOK: begin
               // A start coinciding with a tick discards the tick; presc stays put.
               if (start_pulse) begin
                  state                      <= S_PAUSE;
                  {start, idle, paused, done} <= flags_of(S_PAUSE);
               end else if (tick) begin
                  presc   <= '0;
                  minutes <= dec_min;
                  seconds <= dec_sec;
                  if (dec_zero) begin
                     state                      <= S_DONE;
                     done_cnt                   <= '0;
                     {start, idle, paused, done} <= flags_of(S_DONE);
                  end
               end else begin
                  presc <= presc + PW'(1);
               end
            end
            S_PAUSE: begin
               if (start_pulse) begin
                  if (!time_zero) begin
                     state                      <= S_COOK;
                     {start, idle, paused, done} <= flags_of(S_COOK);
                  end else begin
                     state                      <= S_IDLE;
                     {start, idle, paused, done} <= flags_of(S_IDLE);
                  end
               end else if (!load_valid) begin
                  if (up_pulse) begin
                     minutes <= up_min;
                     seconds <= up_sec;
                  end else if (dwn_pulse) begin
                     minutes <= dn_min;
                     seconds <= dn_sec;
                  end
               end
            end
            S_DONE: begin
               if (start_pulse) begin
                  state                      <= S_IDLE;
                  {start, idle, paused, done} <= flags_of(S_IDLE);
               end else if (tick) begin
                  presc <= '0;
                  if (done_cnt == DW'(DONE_SECS - 1)) begin
                     state                      <= S_IDLE;
                     {start, idle, paused, done} <= flags_of(S_IDLE);
                  end else begin
                     done_cnt <= done_cnt + DW'(1);
                  end
               end else begin
                  presc <= presc + PW'(1);
               end
            end
            default: begin
               state                      <= S_IDLE;
               {start, idle, paused, done} <= flags_of(S_IDLE);
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Directed self-checking bench for cook_timer_ctrl (TICK_DIV=10, STEP_SEC=10).
module tb_cook_timer_ctrl;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b0;
   logic       up_pulse = 1'b0, dwn_pulse = 1'b0, start_pulse = 1'b0, load_valid = 1'b0;
   logic [5:0] load_minutes = 6'd0, load_seconds = 6'd0;
   logic [5:0] minutes, seconds;
   logic       start, idle, paused, done;

   int checks = 0;
   int errors = 0;

   cook_timer_ctrl #(
      .TICK_DIV(10), .STEP_SEC(10), .MAX_MIN(59), .DONE_SECS(3)
   ) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .up_pulse(up_pulse), .dwn_pulse(dwn_pulse), .start_pulse(start_pulse),
      .load_valid(load_valid), .load_minutes(load_minutes), .load_seconds(load_seconds),
      .minutes(minutes), .seconds(seconds),
      .start(start), .idle(idle), .paused(paused), .done(done)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk_time(input string tag, input int m, input int s);
      checks++;
      assert ({26'd0, minutes, seconds} === 32'((m << 6) | s))
      else begin
         errors++;
         $error("FAIL %s observed=%0d:%0d expected=%0d:%0d", tag, minutes, seconds, m, s);
      end
   endtask

   // Expected flags as {start, idle, paused, done}.
   task automatic chk_flags(input string tag, input logic [3:0] exp);
      checks++;
      assert ({start, idle, paused, done} === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b (start,idle,paused,done)", tag,
                {start, idle, paused, done}, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic press_up();
      up_pulse = 1'b1; cyc(1); up_pulse = 1'b0;
   endtask

   task automatic press_dn();
      dwn_pulse = 1'b1; cyc(1); dwn_pulse = 1'b0;
   endtask

   task automatic press_start();
      start_pulse = 1'b1; cyc(1); start_pulse = 1'b0;
   endtask

   task automatic do_load(input int m, input int s);
      load_minutes = 6'(m); load_seconds = 6'(s); load_valid = 1'b1;
      cyc(1);
      load_valid = 1'b0;
   endtask

   initial begin
      // 1. asynchronous reset mid-clock, then inputs ignored while held
      #3 sys_rst = 1'b1;
      #1;
      chk_time("rst_async_time", 0, 0);
      chk_flags("rst_async_flags", 4'b0100);
      @(negedge sys_clk);
      up_pulse = 1'b1; start_pulse = 1'b1; load_valid = 1'b1;
      load_minutes = 6'd5; load_seconds = 6'd5;
      cyc(2);
      up_pulse = 1'b0; start_pulse = 1'b0; load_valid = 1'b0;
      chk_time("rst_hold_time", 0, 0);
      chk_flags("rst_hold_flags", 4'b0100);
      sys_rst = 1'b0;
      cyc(1);

      // 2. up/down editing in IDLE, saturation at 0:00, start at 0:00 ignored
      press_up(); press_up(); press_up();
      chk_time("up3", 0, 30);
      press_dn(); chk_time("dn1", 0, 20);
      press_dn(); chk_time("dn2", 0, 10);
      press_dn(); chk_time("dn3", 0, 0);
      press_dn(); chk_time("dn4_sat", 0, 0);
      press_start();
      chk_flags("start_at_zero", 4'b0100);

      // 3. cook 0:02 to DONE, then DONE holds 3 ticks
      do_load(0, 2);
      chk_time("load_0_02", 0, 2);
      press_start();
      chk_flags("cook_enter", 4'b1000);
      cyc(9);  chk_time("cook_pre_tick", 0, 2);
      cyc(1);  chk_time("cook_tick1", 0, 1);
      cyc(10); chk_time("cook_tick2", 0, 0);
      chk_flags("done_enter", 4'b0001);
      cyc(29); chk_flags("done_hold", 4'b0001);
      cyc(1);  chk_flags("done_to_idle", 4'b0100);

      // 4. pause holds time and prescaler; resume continues mid-second
      do_load(1, 0);
      press_start();
      cyc(10); chk_time("cook_1_00_dec", 0, 59);
      cyc(5);
      press_start();
      chk_flags("pause_enter", 4'b0010);
      cyc(50);
      chk_time("pause_hold", 0, 59);
      chk_flags("pause_hold_flags", 4'b0010);
      press_up();
      chk_time("pause_up", 1, 9);
      press_start();
      chk_flags("resume", 4'b1000);
      cyc(4); chk_time("resume_pre_tick", 1, 9);
      cyc(1); chk_time("resume_tick", 1, 8);

      // pause, step down to 0:00, start returns to IDLE
      press_start();
      repeat (7) press_dn();
      chk_time("pause_dn_sat", 0, 0);
      chk_flags("pause_still", 4'b0010);
      press_start();
      chk_flags("pause_zero_idle", 4'b0100);

      // 5. clamping and saturation limits
      do_load(63, 63); chk_time("load_clamp", 59, 59);
      press_up();      chk_time("up_sat", 59, 59);
      press_dn();      chk_time("dn_from_max", 59, 49);
      do_load(0, 5);
      press_dn();      chk_time("dn_small_sat", 0, 0);
      do_load(0, 50);
      start_pulse = 1'b1; up_pulse = 1'b1;
      cyc(1);
      start_pulse = 1'b0; up_pulse = 1'b0;
      chk_flags("start_up_same", 4'b1000);
      chk_time("start_up_time", 0, 50);
      do_load(0, 5);
      chk_time("load_in_cook", 0, 50);

      // 6. reset during COOK at 0:40
      cyc(99);
      chk_time("cook_0_40", 0, 40);
      #2 sys_rst = 1'b1;
      #1;
      chk_time("rst_cook_time", 0, 0);
      chk_flags("rst_cook_flags", 4'b0100);
      @(negedge sys_clk);
      sys_rst = 1'b0;
      cyc(1);
      do_load(0, 1);
      press_start();
      cyc(9);  chk_flags("post_rst_cook", 4'b1000);
      cyc(1);  chk_flags("post_rst_done", 4'b0001);
      chk_time("post_rst_zero", 0, 0);
      press_start();
      chk_flags("done_start_idle", 4'b0100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
